// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring shift-subtract step per clock.
// Optional MDU_DIVZERO_FLAG_EN adds a div_zero pulse alongside done.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef MDU_DIVZERO_FLAG_EN
  ,
  output logic             div_zero
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            is_div, neg_q, neg_r, b_zero;
  logic [WIDTH-1:0] a_raw, dvs, acc_hi, acc_lo;
  logic [WIDTH:0]  add_s, shl, sub_s;
  logic [WIDTH-1:0] ma, mb;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  // op[0]==0 selects the signed variants; steps always run on magnitudes
  always_comb begin
    ma    = mag(op_a, ~op[0]);
    mb    = mag(op_b, ~op[0]);
    add_s = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dvs} : '0);
    shl   = {acc_hi, acc_lo[WIDTH-1]};
    sub_s = shl - {1'b0, dvs};
  end

  // Datapath: multiply keeps multiplier in acc_lo, divide keeps dividend/quotient there
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      is_div <= op[1];
      neg_q  <= ~op[0] & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
      neg_r  <= ~op[0] & op_a[WIDTH-1];
      b_zero <= (op_b == '0);
      a_raw  <= op_a;
      acc_hi <= '0;
      acc_lo <= op[1] ? ma : mb;
      dvs    <= op[1] ? mb : ma;
    end else if (state == RUN) begin
      if (is_div) begin
        if (!sub_s[WIDTH]) begin
          acc_hi <= sub_s[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
          acc_hi <= shl[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_hi <= add_s[WIDTH:1];
        acc_lo <= {add_s[0], acc_lo[WIDTH-1:1]};
      end
    end
  end

  // Control FSM with registered busy/done/hi/lo
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
`ifdef MDU_DIVZERO_FLAG_EN
      div_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef MDU_DIVZERO_FLAG_EN
      div_zero <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
          end
        end
        RUN: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (is_div && b_zero) begin
            hi <= a_raw;
            lo <= '1;
          end else if (is_div) begin
            hi <= cond_neg(acc_hi, neg_r);
            lo <= cond_neg(acc_lo, neg_q);
          end else begin
            {hi, lo} <= cond_neg2({acc_hi, acc_lo}, neg_q);
          end
`ifdef MDU_DIVZERO_FLAG_EN
          div_zero <= is_div & b_zero;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized self-checking bench for mult_div_unit against a plain-arithmetic reference.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] op_a, op_b;
  logic         busy, done;
  logic [W-1:0] hi, lo;
`ifdef MDU_DIVZERO_FLAG_EN
  logic         div_zero;
`endif

  int n_chk = 0;
  int n_err = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .op_a  (op_a),
    .op_b  (op_b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
`ifdef MDU_DIVZERO_FLAG_EN
    ,
    .div_zero (div_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: {hi, lo} from ordinary 64-bit arithmetic
  function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'd0: r = sa * sb;
      2'd1: r = ua * ub;
      2'd2: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(sa % sb), 32'(sa / sb)};
      default: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {32'(ua % ub), 32'(ua / ub)};
    endcase
    return r;
  endfunction

  // Called at a negedge with the DUT idle (or in its done cycle); returns at the done-cycle negedge
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit noise);
    logic [63:0] exp;
    int edges, busy_n;
    exp   = ref_md(o, a, b);
    start = 1'b1; op = o; op_a = a; op_b = b;
    @(negedge clk);
    start  = 1'b0;
    edges  = 0;
    busy_n = 0;
    while (!done && edges < 100) begin
      if (busy) busy_n++;
      if (noise) begin
        op_a  = $urandom;
        op_b  = $urandom;
        op    = 2'($urandom);
        start = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    chk({tag, ".latency"}, 64'(edges), 64'(W + 1));
    chk({tag, ".busy_cycles"}, 64'(busy_n), 64'(W + 1));
    chk({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, ".hilo"}, {hi, lo}, exp);
`ifdef MDU_DIVZERO_FLAG_EN
    chk({tag, ".div_zero"}, 64'(div_zero), 64'(o[1] && b == 0));
`endif
  endtask

  task automatic idle_after(input string tag);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 64'(done), 64'd0);
    chk({tag, ".idle_busy"}, 64'(busy), 64'd0);
`ifdef MDU_DIVZERO_FLAG_EN
    chk({tag, ".dz_pulse"}, 64'(div_zero), 64'd0);
`endif
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 9));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] hold;
    int seen;
    rst = 1'b1; start = 1'b0; op = 2'd0; op_a = '0; op_b = '0;
    #12;
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("mult_neg3x5", 2'd0, 32'hFFFF_FFFD, 32'd5, 0);
    chk("mult_neg3x5.value", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    idle_after("mult_neg3x5");

    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("multu_max.value", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("div_b2b", 2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div_b2b.value", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    idle_after("div_b2b");

    run_op("divu_zero", 2'd3, 32'd100, 32'd0, 0);
    chk("divu_zero.value", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    idle_after("divu_zero");

    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("div_ovf.value", {hi, lo}, 64'h0000_0000_8000_0000);
    run_op("divu_3", 2'd3, 32'h8000_0000, 32'd3, 0);
    chk("divu_3.value", {hi, lo}, 64'h0000_0002_2AAA_AAAA);
    idle_after("divu_3");

    // Restart while busy plus operand churn must not disturb the captured operation
    run_op("multu_noise", 2'd1, 32'd6, 32'd7, 1);
    chk("multu_noise.value", {hi, lo}, 64'd42);
    idle_after("multu_noise");
    hold = {hi, lo};
    repeat (3) @(negedge clk);
    chk("hold.hilo", {hi, lo}, hold);

    // Asynchronous abort in the middle of a divide
    start = 1'b1; op = 2'd2; op_a = 32'd1000; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    chk("abort.hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort.no_done", 64'(seen), 64'd0);
    run_op("after_abort", 2'd1, 32'd2, 32'd3, 0);
    chk("after_abort.value", {hi, lo}, 64'd6);
    idle_after("after_abort");

    // Random operations, some chained in the done cycle
    for (int i = 0; i < 24; i++) begin
      run_op($sformatf("rnd%0d", i), 2'($urandom), pick(), pick(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_after($sformatf("rnd%0d", i));
    end
    idle_after("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
